// File: rtl/icache_responder_if.sv
// Fetch-side and instruction-memory-side signals of the icache responder.
// The cache takes the slave modport; fetch/memory models take the master modport.
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iload, iwait,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iload, iwait,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache with a wait-based fill port.
// Define ICACHE_STATS_EN to build the hit/miss counters; otherwise they read as 0.
module icache_responder #(
  parameter int unsigned NSETS = 16
) (
  input logic               CLK,
  input logic               nRST,
  icache_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NSETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_e;

  state_e             state_q, state_d;
  logic [29:0]        miss_word_q, miss_word_d;
  logic [NSETS-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [NSETS];
  logic [31:0]        data_q [NSETS];

  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               lookup_hit;
  logic               ihit_w;
  logic               fill_en;
  logic               miss_start;

  assign req_idx    = bus.imemaddr[IDX_W+1:2];
  assign req_tag    = bus.imemaddr[31:IDX_W+2];
  assign fill_idx   = miss_word_q[IDX_W-1:0];
  assign fill_tag   = miss_word_q[29:IDX_W];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_word_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_word_q <= miss_word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_word_d = miss_word_q;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !lookup_hit && !bus.flush) begin
          state_d     = MISS;
          miss_word_d = bus.imemaddr[31:2];
        end
      end
      MISS: begin
        // flush aborts the fill, so it leaves MISS regardless of iwait
        if (bus.flush || !bus.iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit_w       = 1'b0;
    fill_en      = 1'b0;
    miss_start   = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.imemload = '0;
    case (state_q)
      IDLE: begin
        ihit_w     = bus.imemREN && lookup_hit && !bus.flush;
        miss_start = bus.imemREN && !lookup_hit && !bus.flush;
        if (ihit_w) bus.imemload = data_q[req_idx];
      end
      MISS: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {miss_word_q, 2'b00};
        fill_en   = !bus.iwait && !bus.flush;
      end
      default: ;
    endcase
  end

  assign bus.ihit = ihit_w;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit_w)     hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: table of fetches plus flush/reset sequences.
module tb_icache_responder;

  logic CLK;
  logic nRST;

  icache_responder_if bus();

  icache_responder #(.NSETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        miss;
    int unsigned nwait;
    logic [31:0] fill;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] sb_q [$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hit_count"},  bus.hit_count,  32'(exp_hits));
    chk({tag, "_miss_count"}, bus.miss_count, 32'(exp_misses));
`else
    chk({tag, "_hit_count"},  bus.hit_count,  32'd0);
    chk({tag, "_miss_count"}, bus.miss_count, 32'd0);
`endif
  endtask

  // One fetch: expected word goes to the scoreboard at drive time, popped on ihit.
  task automatic fetch(input vec_t v);
    logic got;
    got = 1'b0;
    @(negedge CLK);
    bus.imemREN  = 1'b1;
    bus.imemaddr = v.addr;
    bus.iwait    = 1'b1;
    sb_q.push_back(v.exp_data);
    #1;
    if (v.miss) begin
      chk("lookup_ihit", {31'd0, bus.ihit}, 32'd0);
      for (int unsigned c = 0; c <= v.nwait; c++) begin
        @(negedge CLK); #1;
        chk("miss_iREN",  {31'd0, bus.iREN}, 32'd1);
        chk("miss_iaddr", bus.iaddr, {v.addr[31:2], 2'b00});
        chk("miss_ihit",  {31'd0, bus.ihit}, 32'd0);
        if (c == v.nwait) begin
          bus.iwait = 1'b0;
          bus.iload = v.fill;
        end
      end
      @(negedge CLK);
      bus.iwait = 1'b1;
      bus.iload = '0;
      #1;
      exp_misses++;
    end
    for (int c = 0; c < 8 && !got; c++) begin
      if (bus.ihit) begin
        got = 1'b1;
        chk("hit_latency", 32'(c), 32'd0);
        chk("ihit_data", bus.imemload, sb_q.pop_front());
        chk("hit_iREN", {31'd0, bus.iREN}, 32'd0);
        exp_hits++;
      end else begin
        @(negedge CLK); #1;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ihit_timeout: no ihit for addr %h within 8 cycles", v.addr);
      void'(sb_q.pop_front());
    end
    bus.imemREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_1000, 1'b1, 2, 32'hACE1_ACE1, 32'hACE1_ACE1};
    vecs[1] = '{32'h0000_1002, 1'b0, 0, 32'h0,         32'hACE1_ACE1};
    vecs[2] = '{32'h0000_1040, 1'b1, 0, 32'hACE2_ACE2, 32'hACE2_ACE2};
    vecs[3] = '{32'h0000_1040, 1'b0, 0, 32'h0,         32'hACE2_ACE2};
    vecs[4] = '{32'h0000_1000, 1'b1, 1, 32'hACE1_ACE1, 32'hACE1_ACE1};
    vecs[5] = '{32'h0000_2004, 1'b1, 0, 32'h1234_5678, 32'h1234_5678};
    vecs[6] = '{32'h0000_1000, 1'b0, 0, 32'h0,         32'hACE1_ACE1};
    vecs[7] = '{32'h0000_2007, 1'b0, 0, 32'h0,         32'h1234_5678};

    nRST = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.flush    = 1'b0;
    bus.iload    = '0;
    bus.iwait    = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ihit",     {31'd0, bus.ihit}, 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);
    chk("rst_iREN",     {31'd0, bus.iREN}, 32'd0);
    chk("rst_iaddr",    bus.iaddr, 32'd0);
    check_counters("rst");
    nRST = 1'b1;

    for (int i = 0; i < 8; i++) fetch(vecs[i]);
    @(negedge CLK); #1;
    check_counters("table");

    // Flush in IDLE: no hit, no miss started, line invalidated.
    @(negedge CLK);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_1000; bus.flush = 1'b1;
    #1;
    chk("flush_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("flush_imemload", bus.imemload, 32'd0);
    @(negedge CLK);
    bus.flush = 1'b0; bus.imemREN = 1'b0;
    #1;
    chk("flush_no_miss_iREN", {31'd0, bus.iREN}, 32'd0);
    v = '{32'h0000_1000, 1'b1, 0, 32'hACE1_ACE1, 32'hACE1_ACE1};
    fetch(v);

    // Flush in the same cycle as iwait=0 aborts the fill.
    @(negedge CLK);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_3008;
    @(negedge CLK); #1;
    chk("abort_iREN", {31'd0, bus.iREN}, 32'd1);
    chk("abort_iaddr", bus.iaddr, 32'h0000_3008);
    bus.iwait = 1'b0; bus.iload = 32'hDEAD_BEEF; bus.flush = 1'b1;
    exp_misses++;
    @(negedge CLK);
    bus.iwait = 1'b1; bus.iload = '0; bus.flush = 1'b0;
    #1;
    chk("abort_idle_iREN", {31'd0, bus.iREN}, 32'd0);
    chk("abort_no_ihit", {31'd0, bus.ihit}, 32'd0);
    bus.imemREN = 1'b0;
    v = '{32'h0000_3008, 1'b1, 0, 32'h0BAD_F00D, 32'h0BAD_F00D};
    fetch(v);
    @(negedge CLK); #1;
    check_counters("flush");

    // Asynchronous reset while a miss is outstanding.
    @(negedge CLK);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_4010;
    @(negedge CLK); #1;
    chk("pre_rst_iREN", {31'd0, bus.iREN}, 32'd1);
    bus.iwait = 1'b0; bus.iload = 32'hFFFF_FFFF;
    #2 nRST = 1'b0;
    #1;
    chk("midrst_iREN", {31'd0, bus.iREN}, 32'd0);
    chk("midrst_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("midrst_iaddr", bus.iaddr, 32'd0);
    exp_hits = 0; exp_misses = 0;
    check_counters("midrst");
    repeat (2) @(negedge CLK);
    bus.imemREN = 1'b0; bus.iwait = 1'b1; bus.iload = '0;
    nRST = 1'b1;
    @(negedge CLK); #1;
    check_counters("post_rst");
    v = '{32'h0000_3008, 1'b1, 0, 32'h0BAD_F00D, 32'h0BAD_F00D};
    fetch(v);
    v = '{32'h0000_4010, 1'b1, 1, 32'h5555_AAAA, 32'h5555_AAAA};
    fetch(v);
    @(negedge CLK); #1;
    check_counters("final");
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
